// File: rtl/imem_loader_if.sv
// Boot loader bus: UART byte strobe in, instruction memory
// write port and core release status out.
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst;
  logic        done;
  logic        error;

  modport master (
    input  rx_valid,
    input  rx_data,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output core_rst,
    output done,
    output error
  );

  modport slave (
    output rx_valid,
    output rx_data,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  core_rst,
    input  done,
    input  error
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time image loader: framed UART bytes become little-endian
// word writes; the core stays in reset until a verified image lands.
module imem_loader #(
  parameter int         DEPTH = 512,
  parameter logic [7:0] SYNC  = 8'h5A
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [16:0] MAXN = 17'(DEPTH);

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] widx;
  logic [1:0]  lane;
  logic [7:0]  csum;
  logic [23:0] wbuf;

  logic [15:0] n_rx;
  logic [15:0] widx_nx;
  logic [7:0]  b;

  assign b       = bus.rx_data;
  assign n_rx    = {b, cnt[7:0]};
  assign widx_nx = widx + 16'd1;

  // Frame parser, word assembler and registered write/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      widx          <= '0;
      lane          <= '0;
      csum          <= '0;
      wbuf          <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.core_rst  <= 1'b1;
      bus.done      <= 1'b0;
      bus.error     <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      if (bus.rx_valid) begin
        unique case (state)
          IDLE: begin
            if (b == SYNC) state <= LEN0;
          end
          LEN0: begin
            cnt   <= {8'h00, b};
            state <= LEN1;
          end
          LEN1: begin
            cnt  <= n_rx;
            widx <= '0;
            lane <= '0;
            csum <= '0;
            if ({1'b0, n_rx} > MAXN) begin
              state     <= ERR;
              bus.error <= 1'b1;
            end else if (n_rx == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            csum <= csum + b;
            lane <= lane + 2'd1;
            if (lane == 2'd3) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= {widx[9:0], 2'b00};
              bus.mem_wdata <= {b, wbuf};
              widx          <= widx_nx;
              if (widx_nx == cnt) state <= CSUM;
            end else begin
              wbuf[lane*8 +: 8] <= b;
            end
          end
          CSUM: begin
            if (b == csum) begin
              state        <= DONE;
              bus.done     <= 1'b1;
              bus.core_rst <= 1'b0;
            end else begin
              state     <= ERR;
              bus.error <= 1'b1;
            end
          end
          ERR: begin
            if (b == SYNC) begin
              state     <= LEN0;
              bus.error <= 1'b0;
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: hand-built frames, write
// monitor queue and expected values computed here.
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;

  imem_loader_if bus();

  imem_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  logic [11:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] img[512];

  // Capture every write pulse away from the active edge.
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] b, input bit burst);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    if (!burst) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
  endtask

  task automatic quiet();
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wa.delete();
    wd.delete();
  endtask

  task automatic send_frame(input int n, input bit burst,
                            input bit bad);
    logic [7:0] s;
    logic [31:0] w;
    s = 8'h00;
    put(8'h5A, burst);
    put(8'(n), burst);
    put(8'(n >> 8), burst);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      for (int k = 0; k < 4; k++) begin
        s = s + w[k*8 +: 8];
        put(w[k*8 +: 8], burst);
      end
    end
    put(bad ? ~s : s, burst);
    quiet();
  endtask

  task automatic chk_reset_vals(input string p);
    check({p, "_we"},    32'(bus.mem_we),    32'd0);
    check({p, "_addr"},  32'(bus.mem_addr),  32'd0);
    check({p, "_wdata"}, bus.mem_wdata,      32'd0);
    check({p, "_crst"},  32'(bus.core_rst),  32'd1);
    check({p, "_done"},  32'(bus.done),      32'd0);
    check({p, "_err"},   32'(bus.error),     32'd0);
  endtask

  task automatic basic_bytes();
    put(8'h5A, 0); put(8'h02, 0); put(8'h00, 0);
    put(8'h13, 0); put(8'h00, 0); put(8'h00, 0);
    put(8'h00, 0);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    img[0] = 32'h00000013;
    img[1] = 32'h200005B7;

    // reset values
    @(negedge clk);
    chk_reset_vals("rst");
    do_reset();

    // basic load with exact write timing
    basic_bytes();
    check("b_we0",   32'(bus.mem_we),   32'd1);
    check("b_addr0", 32'(bus.mem_addr), 32'h000);
    check("b_data0", bus.mem_wdata,     32'h00000013);
    put(8'hB7, 0);
    check("b_we_drop", 32'(bus.mem_we), 32'd0);
    check("b_hold",    bus.mem_wdata,   32'h00000013);
    put(8'h05, 0); put(8'h00, 0); put(8'h20, 0);
    check("b_addr1", 32'(bus.mem_addr), 32'h004);
    check("b_data1", bus.mem_wdata,     32'h200005B7);
    check("b_pre_done", 32'(bus.done),  32'd0);
    put(8'hEF, 0);
    check("b_done", 32'(bus.done),     32'd1);
    check("b_crst", 32'(bus.core_rst), 32'd0);
    check("b_err",  32'(bus.error),    32'd0);
    check("b_nwr",  32'(wa.size()),    32'd2);

    // bad checksum, then correct retransmission
    do_reset();
    send_frame(2, 0, 1);
    check("bc_err",  32'(bus.error),    32'd1);
    check("bc_crst", 32'(bus.core_rst), 32'd1);
    check("bc_done", 32'(bus.done),     32'd0);
    check("bc_nwr",  32'(wa.size()),    32'd2);
    put(8'h5A, 0);
    check("bc_clr",  32'(bus.error),    32'd0);
    put(8'h02, 0); put(8'h00, 0);
    put(8'h13, 0); put(8'h00, 0); put(8'h00, 0); put(8'h00, 0);
    put(8'hB7, 0); put(8'h05, 0); put(8'h00, 0); put(8'h20, 0);
    put(8'hEF, 0);
    check("bc_done2", 32'(bus.done),    32'd1);
    check("bc_nwr2",  32'(wa.size()),   32'd4);

    // oversize count 513
    do_reset();
    put(8'h5A, 0); put(8'h01, 0);
    check("ov_err_pre", 32'(bus.error), 32'd0);
    put(8'h02, 0);
    check("ov_err", 32'(bus.error),  32'd1);
    check("ov_nwr", 32'(wa.size()),  32'd0);
    put(8'h13, 0);
    check("ov_ign", 32'(bus.error),  32'd1);
    send_frame(2, 0, 0);
    check("ov_done", 32'(bus.done),   32'd1);
    check("ov_err2", 32'(bus.error),  32'd0);
    check("ov_nwr2", 32'(wa.size()),  32'd2);

    // garbage then empty frame
    do_reset();
    put(8'hFF, 0); put(8'h00, 0);
    put(8'h5A, 0); put(8'h00, 0); put(8'h00, 0);
    check("z_pre", 32'(bus.done), 32'd0);
    put(8'h00, 0);
    check("z_done", 32'(bus.done),    32'd1);
    check("z_crst", 32'(bus.core_rst), 32'd0);
    check("z_nwr",  32'(wa.size()),    32'd0);

    // full 512-word image, back-to-back bytes
    do_reset();
    for (int i = 0; i < 512; i++)
      img[i] = 32'(i) * 32'h9E3779B1 + 32'h01020304;
    send_frame(512, 1, 0);
    check("f_nwr",  32'(wa.size()),  32'd512);
    check("f_done", 32'(bus.done),   32'd1);
    check("f_last", 32'(bus.mem_addr), 32'h7FC);
    for (int i = 0; i < 512; i++) begin
      if (i < wa.size()) begin
        check("f_addr", 32'(wa[i]), 32'(i) << 2);
        check("f_data", wd[i],      img[i]);
      end
    end

    // reset in the middle of the payload
    do_reset();
    img[0] = 32'h00000013;
    img[1] = 32'h200005B7;
    send_frame(2, 0, 1);
    put(8'h5A, 0); put(8'h01, 0); put(8'h00, 0);
    put(8'h11, 0); put(8'h22, 0); put(8'h33, 0);
    check("m_pre_addr", 32'(bus.mem_addr), 32'h004);
    #3 reset = 1'b1;
    #1 chk_reset_vals("mid");
    @(negedge clk);
    reset = 1'b0;
    wa.delete();
    wd.delete();
    img[0] = 32'hAABBCCDD;
    send_frame(1, 1, 0);
    check("m_nwr",  32'(wa.size()), 32'd1);
    if (wa.size() > 0) begin
      check("m_addr", 32'(wa[0]), 32'h000);
      check("m_data", wd[0],      32'hAABBCCDD);
    end
    check("m_done", 32'(bus.done), 32'd1);

    // frames after done are ignored
    wa.delete();
    wd.delete();
    send_frame(1, 0, 0);
    send_frame(1, 1, 1);
    check("i_nwr",  32'(wa.size()),    32'd0);
    check("i_done", 32'(bus.done),     32'd1);
    check("i_crst", 32'(bus.core_rst), 32'd0);
    check("i_err",  32'(bus.error),    32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
